// File: rtl/pc_fetch_reg.sv
// Fetch-stage program counter and IF/ID pipeline latch.
// Selects branch/jump/sequential next PC and inserts bubbles on redirect or flush.
module pc_fetch_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_seq,
    input  logic [31:0] i_imem_instr,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_pc4,
    output logic [31:0] o_if_id_instr,
    output logic        o_if_id_valid,
    output logic        o_misalign_err
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_misalign_err;

    logic        w_redirect;
    logic        w_bubble;
    logic [31:0] w_target;
    logic [31:0] w_target_aligned;
    logic        w_target_misaligned;

    // Branch comes from EX, so it is older than a jump from ID and wins.
    assign w_redirect = i_branch_taken | i_jump;
    assign w_target   = i_branch_taken ? i_branch_target : i_jump_target;
    assign w_target_aligned    = {w_target[31:2], 2'b00};
    assign w_target_misaligned = w_redirect & (w_target[1:0] != 2'b00);
    assign w_bubble = w_redirect | i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_target_aligned;
        end else if (!i_stall) begin
            r_pc <= i_pc_seq;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_id_pc4   <= 32'h0000_0000;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_bubble) begin
            r_if_id_pc4   <= 32'h0000_0000;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!i_stall) begin
            r_if_id_pc4   <= i_pc_seq;
            r_if_id_instr <= i_imem_instr;
            r_if_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_misalign_err <= 1'b0;
        end else if (w_target_misaligned) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign o_pc           = r_pc;
    assign o_if_id_pc4    = r_if_id_pc4;
    assign o_if_id_instr  = r_if_id_instr;
    assign o_if_id_valid  = r_if_id_valid;
    assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Randomized scoreboard bench for pc_fetch_reg.
// Stimulus pushes expected state; a monitor pops and compares after each edge.
module tb_pc_fetch_reg;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        v;
        logic        mis;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_seq;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;

    int   n_vec = 0;
    int   n_bad = 0;
    st_t  m;
    st_t  q[$];

    always #5 clk = ~clk;

    pc_fetch_reg #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_pc_seq(pc_seq),
        .i_imem_instr(imem_instr),
        .i_stall(stall),
        .i_flush(flush),
        .i_branch_taken(br),
        .i_branch_target(bt),
        .i_jump(jp),
        .i_jump_target(jt),
        .o_pc(pc),
        .o_if_id_pc4(pc4),
        .o_if_id_instr(instr),
        .o_if_id_valid(valid),
        .o_misalign_err(mis)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input st_t e);
        check({tag, " pc"}, pc, e.pc);
        check({tag, " if_id_pc4"}, pc4, e.pc4);
        check({tag, " if_id_instr"}, instr, e.instr);
        check({tag, " if_id_valid"}, {31'd0, valid}, {31'd0, e.v});
        check({tag, " misalign_err"}, {31'd0, mis}, {31'd0, e.mis});
    endtask

    function automatic st_t reset_state();
        st_t s;
        s.pc = RPC;
        s.pc4 = 32'd0;
        s.instr = NOP;
        s.v = 1'b0;
        s.mis = 1'b0;
        return s;
    endfunction

    // Next state from the plain priority rules: redirect, then stall, then advance.
    function automatic st_t next_state(input st_t s);
        st_t n;
        logic [31:0] t;
        n = s;
        t = br ? bt : jt;
        if (br || jp) begin
            if (t % 4 != 0) n.mis = 1'b1;
            n.pc = t - (t % 4);
        end else if (!stall) begin
            n.pc = pc_seq;
        end
        if (br || jp || flush) begin
            n.pc4 = 32'd0;
            n.instr = NOP;
            n.v = 1'b0;
        end else if (!stall) begin
            n.pc4 = pc_seq;
            n.instr = imem_instr;
            n.v = 1'b1;
        end
        return n;
    endfunction

    // Called at a negedge: drive inputs, queue expectation, wait a cycle.
    task automatic cyc(input logic st, input logic fl,
                       input logic b, input logic [31:0] btg,
                       input logic j, input logic [31:0] jtg);
        stall = st;
        flush = fl;
        br = b;
        bt = btg;
        jp = j;
        jt = jtg;
        imem_instr = $urandom;
        pc_seq = m.pc + 32'd4;
        m = next_state(m);
        q.push_back(m);
        @(negedge clk);
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m = reset_state();
        check_all("async_rst", m);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all("edge", e);
            end
        end
    end

    initial begin : stim
        logic [31:0] t;
        rst = 1'b1;
        stall = 0;
        flush = 0;
        br = 0;
        bt = 0;
        jp = 0;
        jt = 0;
        pc_seq = 0;
        imem_instr = 0;
        m = reset_state();
        #2;
        check_all("reset", m);
        @(negedge clk);
        rst = 1'b0;

        free(2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        free(2);

        cyc(0, 0, 1, 32'h40, 1, 32'h80);
        free(2);

        cyc(1, 0, 1, 32'h102, 0, 0);
        free(3);

        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        free(2);

        cyc(1, 0, 1, 32'h203, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        async_reset();
        cyc(1, 1, 0, 0, 0, 0);
        free(2);

        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) async_reset();
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, t,
                $urandom_range(0, 9) == 0, {t[15:0], t[31:16]});
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d left expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
